// File: rtl/dec_scan.sv
// Registered one-hot decoder with a built-in scan sequencer.
// Direct mode latches a select value; scan mode walks one active line with a fixed dwell.
module dec_scan #(
  parameter int N       = 4,
  parameter int NUM_OUT = 16,
  parameter int DWELL   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               load,
  input  logic [N-1:0]       sel,
  output logic [NUM_OUT-1:0] y,
  output logic [N-1:0]       idx,
  output logic               wrap,
  output logic               oor
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [N-1:0]  IDX_LAST  = N'(NUM_OUT - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DWELL - 1);

  typedef enum logic {DIRECT, SCAN} state_t;

  state_t        state;
  logic [DW-1:0] dcnt;
  logic          frozen;
  logic [N-1:0]  idx_next;
  logic          sel_ok;

  function automatic logic [NUM_OUT-1:0] onehot(input logic [N-1:0] i);
    return NUM_OUT'(1) << i;
  endfunction

  // Wrap at NUM_OUT-1 rather than 2**N-1 so idx never names a missing line.
  assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  assign sel_ok   = 32'(sel) < NUM_OUT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DIRECT;
      y      <= '0;
      idx    <= '0;
      dcnt   <= '0;
      frozen <= 1'b0;
      wrap   <= 1'b0;
      oor    <= 1'b0;
    end else begin
      wrap  <= 1'b0;
      oor   <= 1'b0;
      state <= mode ? SCAN : DIRECT;
      if (state == DIRECT && mode) begin
        idx    <= '0;
        dcnt   <= '0;
        frozen <= 1'b0;
        y      <= en ? onehot('0) : '0;
      end else if (state == SCAN && !mode) begin
        y      <= '0;
        dcnt   <= '0;
        frozen <= 1'b0;
      end else if (state == DIRECT) begin
        if (!en) begin
          y <= '0;
        end else if (load) begin
          if (sel_ok) begin
            y   <= onehot(sel);
            idx <= sel;
          end else begin
            y   <= '0;
            oor <= 1'b1;
          end
        end
      end else begin
        // After a freeze, the first enabled cycle only re-lights the line.
        if (!en) begin
          y      <= '0;
          frozen <= 1'b1;
        end else if (frozen) begin
          y      <= onehot(idx);
          frozen <= 1'b0;
        end else if (dcnt == DCNT_LAST) begin
          dcnt <= '0;
          idx  <= idx_next;
          y    <= onehot(idx_next);
          wrap <= (idx_next == '0);
        end else begin
          dcnt <= dcnt + 1'b1;
          y    <= onehot(idx);
        end
      end
    end
  end

endmodule

// File: tb/tb_dec_scan.sv
// Directed bench for dec_scan: three parameterisations share one stimulus stream,
// expectations are queued per step and compared after the following clock edge.
module tb_dec_scan;

  logic clk, rst, en, mode, load;
  logic [3:0] sel;

  logic [15:0] ya;
  logic [9:0]  yb;
  logic [3:0]  yc;
  logic [3:0]  idxa, idxb, idxc;
  logic        wrapa, wrapb, wrapc, oora, oorb, oorc;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  dut;
    logic [15:0] y;
    logic [3:0]  idx;
    logic        wrap;
    logic        oor;
  } exp_t;

  exp_t  expq[$];
  string tagq[$];

  dec_scan #(.N(4), .NUM_OUT(16), .DWELL(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
    .y(ya), .idx(idxa), .wrap(wrapa), .oor(oora));

  dec_scan #(.N(4), .NUM_OUT(10), .DWELL(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
    .y(yb), .idx(idxb), .wrap(wrapb), .oor(oorb));

  dec_scan #(.N(4), .NUM_OUT(4), .DWELL(3)) dut_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
    .y(yc), .idx(idxc), .wrap(wrapc), .oor(oorc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic e, input logic m,
                               input logic l, input logic [3:0] s);
    rst  = r;
    en   = e;
    mode = m;
    load = l;
    sel  = s;
  endtask

  task automatic expectOut(input string tag, input logic [1:0] d, input logic [15:0] ey,
                           input logic [3:0] ei, input logic ew, input logic eo);
    exp_t e;
    e.dut  = d;
    e.y    = ey;
    e.idx  = ei;
    e.wrap = ew;
    e.oor  = eo;
    expq.push_back(e);
    tagq.push_back(tag);
  endtask

  task automatic checkOutput();
    exp_t        e;
    string       t;
    logic [15:0] oy;
    logic [3:0]  oi;
    logic        ow, oo;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      t = tagq.pop_front();
      case (e.dut)
        2'd0:    begin oy = ya;            oi = idxa; ow = wrapa; oo = oora; end
        2'd1:    begin oy = {6'b0, yb};    oi = idxb; ow = wrapb; oo = oorb; end
        default: begin oy = {12'b0, yc};   oi = idxc; ow = wrapc; oo = oorc; end
      endcase
      total += 4;
      assert (oy === e.y) else begin
        bad++;
        $error("[TB] FAIL %s y: got=%h want=%h", t, oy, e.y);
      end
      assert (oi === e.idx) else begin
        bad++;
        $error("[TB] FAIL %s idx: got=%0d want=%0d", t, oi, e.idx);
      end
      assert (ow === e.wrap) else begin
        bad++;
        $error("[TB] FAIL %s wrap: got=%b want=%b", t, ow, e.wrap);
      end
      assert (oo === e.oor) else begin
        bad++;
        $error("[TB] FAIL %s oor: got=%b want=%b", t, oo, e.oor);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int line;
    applyStimulus(1, 1, 1, 0, 4'd0);

    // Reset held with scan requested
    expectOut("rst0", 0, 16'h0, 4'd0, 0, 0);
    tick();
    expectOut("rst1_a", 0, 16'h0, 4'd0, 0, 0);
    expectOut("rst1_c", 2, 16'h0, 4'd0, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 0, 4'd0);
    expectOut("idle", 0, 16'h0, 4'd0, 0, 0);
    tick();

    // Direct decode across every select value
    for (int s = 0; s < 16; s++) begin
      applyStimulus(0, 1, 0, 1, 4'(s));
      expectOut($sformatf("dec%0d", s), 0, 16'(1) << s, 4'(s), 0, 0);
      tick();
    end
    applyStimulus(0, 1, 0, 0, 4'd2);
    expectOut("hold", 0, 16'h8000, 4'd15, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 4'd3);
    expectOut("blank", 0, 16'h0, 4'd15, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 0, 4'd3);
    expectOut("unblank", 0, 16'h0, 4'd15, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 1, 4'd3);
    expectOut("reload", 0, 16'h0008, 4'd3, 0, 0);
    tick();

    // Out-of-range loads on the 10-output instance
    applyStimulus(1, 1, 0, 0, 4'd0);
    expectOut("b_rst", 1, 16'h0, 4'd0, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 1, 4'd7);
    expectOut("b_sel7", 1, 16'h0080, 4'd7, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 1, 4'd12);
    expectOut("b_sel12", 1, 16'h0, 4'd7, 0, 1);
    tick();
    applyStimulus(0, 1, 0, 0, 4'd12);
    expectOut("b_oor_clr", 1, 16'h0, 4'd7, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 1, 4'd9);
    expectOut("b_sel9", 1, 16'h0200, 4'd9, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 1, 4'd10);
    expectOut("b_sel10", 1, 16'h0, 4'd9, 0, 1);
    tick();

    // Full scan on the 4-output, dwell-3 instance
    applyStimulus(1, 1, 0, 0, 4'd0);
    expectOut("c_rst", 2, 16'h0, 4'd0, 0, 0);
    tick();
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 1, 1, 0, 4'd0);
      line = (k / 3) % 4;
      expectOut($sformatf("scan%0d", k), 2, 16'(1) << line, 4'(line),
                (k > 0) && (k % 12 == 0), 0);
      tick();
    end

    // Freeze while idx=2, dcnt=1
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 1, 0, 4'd0);
      expectOut($sformatf("frz%0d", k), 2, 16'h0, 4'd2, 0, 0);
      tick();
    end
    applyStimulus(0, 1, 1, 0, 4'd0);
    expectOut("resume", 2, 16'h0004, 4'd2, 0, 0);
    tick();
    expectOut("resume1", 2, 16'h0004, 4'd2, 0, 0);
    tick();
    expectOut("resume2", 2, 16'h0008, 4'd3, 0, 0);
    tick();

    // Mode switches, load ignored on scan entry, reset mid-dwell
    applyStimulus(0, 1, 0, 0, 4'd0);
    expectOut("to_direct", 2, 16'h0, 4'd3, 0, 0);
    expectOut("to_direct_a", 0, 16'h0, idxa, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 1, 4'd2);
    expectOut("c_sel2", 2, 16'h0004, 4'd2, 0, 0);
    tick();
    applyStimulus(0, 1, 0, 1, 4'd5);
    expectOut("a_sel5", 0, 16'h0020, 4'd5, 0, 0);
    expectOut("c_sel5", 2, 16'h0, 4'd2, 0, 1);
    tick();
    applyStimulus(0, 1, 1, 1, 4'd7);
    expectOut("a_enter", 0, 16'h0001, 4'd0, 0, 0);
    expectOut("c_enter", 2, 16'h0001, 4'd0, 0, 0);
    tick();
    applyStimulus(0, 1, 1, 0, 4'd0);
    expectOut("c_dwell", 2, 16'h0001, 4'd0, 0, 0);
    tick();
    applyStimulus(1, 1, 1, 0, 4'd0);
    expectOut("rst_mid_a", 0, 16'h0, 4'd0, 0, 0);
    expectOut("rst_mid_b", 1, 16'h0, 4'd0, 0, 0);
    expectOut("rst_mid_c", 2, 16'h0, 4'd0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
